mdu_serdes: RTL and testbench

- Bit-serial front end for the multiply/divide unit. Sits between the serial core datapath and the parallel MDU.
- Deserialises rs1/rs2 (LSB first), presents parallel operands plus op with a held valid, and captures the parallel result.
- Serialises the result back to the core one bit per enabled cycle.
- Lets the serial core use the 32-bit parallel MDU without widening its datapath.

---
 rtl/mdu_serdes_pkg.sv | 29 ++
 rtl/mdu_serdes_if.sv | 44 ++++
 rtl/mdu_sipo.sv | 36 +++
 rtl/mdu_serdes.sv | 134 +++++++++++++
 tb/tb_mdu_serdes.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_serdes_pkg.sv
// Shared types and constants for the bit-serial MDU front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: FSM state enum, MDU op encodings, default operand width.
package mdu_serdes_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned OP_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // RISC-V M-extension funct3 ordering.
  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

endpackage

// File: rtl/mdu_serdes_if.sv
// Bundle of core-side serial strobes and MDU-side parallel handshake.
// Latency: n/a (wires only).
// Backpressure: o_mdu_valid is held until i_mdu_ready; serial strobes have no backpressure.
// Modports: slave = the serdes block, master = core + MDU driving it.
interface mdu_serdes_if
  import mdu_serdes_pkg::*;
#(
  parameter int WIDTH = 32
);

  // core -> serdes
  logic             i_start;
  logic [OP_W-1:0]  i_op;
  logic             i_cnt_en;
  logic             i_rs1_bit;
  logic             i_rs2_bit;
  logic             i_rd_en;
  // serdes -> core
  logic             o_busy;
  logic             o_done;
  logic             o_rd_bit;
  // serdes <-> parallel MDU
  logic [WIDTH-1:0] o_mdu_rs1;
  logic [WIDTH-1:0] o_mdu_rs2;
  logic [OP_W-1:0]  o_mdu_op;
  logic             o_mdu_valid;
  logic             i_mdu_ready;
  logic [WIDTH-1:0] i_mdu_rd;

  modport slave (
    input  i_start, i_op, i_cnt_en, i_rs1_bit, i_rs2_bit, i_rd_en,
    input  i_mdu_ready, i_mdu_rd,
    output o_busy, o_done, o_rd_bit,
    output o_mdu_rs1, o_mdu_rs2, o_mdu_op, o_mdu_valid
  );

  modport master (
    output i_start, i_op, i_cnt_en, i_rs1_bit, i_rs2_bit, i_rd_en,
    output i_mdu_ready, i_mdu_rd,
    input  o_busy, o_done, o_rd_bit,
    input  o_mdu_rs1, o_mdu_rs2, o_mdu_op, o_mdu_valid
  );

endinterface

// File: rtl/mdu_sipo.sv
// Serial-in parallel-out register: shifts right, new bit enters at the MSB.
// Latency: bit visible in o_data the cycle after the enabled edge.
// Backpressure: none; i_en is the only qualifier, idle cycles hold the contents.
// Ports: i_clk, i_rst_n (async active-low), i_en, i_bit, o_data[WIDTH].
module mdu_sipo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // LSB-first stream: after WIDTH shifts the first bit sits at [0].
  always_comb begin
    data_d = data_q;
    if (i_en) begin
      data_d = {i_bit, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: rtl/mdu_serdes.sv
// Bit-serial front end for the parallel MDU: deserialise rs1/rs2, hand off, serialise rd.
// Latency: valid the cycle after the last operand bit; rd bit 0 the cycle after i_mdu_ready.
// Backpressure: o_mdu_valid held until i_mdu_ready; shift-out paced by i_rd_en, gaps allowed.
// Ports: i_clk, i_rst_n (async active-low), bus (mdu_serdes_if.slave: core strobes + MDU handshake).
module mdu_serdes
  import mdu_serdes_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mdu_serdes_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [OP_W-1:0]  op_q,    op_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] res_q,   res_d;

  logic             load_en;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;

  // Operand shifters only advance while collecting; they then hold stable for the MDU.
  assign load_en = (state_q == ST_LOAD) && bus.i_cnt_en;

  mdu_sipo #(.WIDTH(WIDTH)) u_rs1_sipo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (load_en),
    .i_bit   (bus.i_rs1_bit),
    .o_data  (rs1_data)
  );

  mdu_sipo #(.WIDTH(WIDTH)) u_rs2_sipo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (load_en),
    .i_bit   (bus.i_rs2_bit),
    .o_data  (rs2_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    valid_d = valid_q;
    done_d  = done_q;
    res_d   = res_q;

    unique case (state_q)
      ST_IDLE: begin
        // Operand bits in the start cycle itself are not collected.
        if (bus.i_start) begin
          op_d    = bus.i_op;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (bus.i_cnt_en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            state_d = ST_EXEC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_EXEC: begin
        // Valid must fall on the ready edge; a divider would restart on a lingering valid.
        if (bus.i_mdu_ready) begin
          res_d   = bus.i_mdu_rd;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (bus.i_rd_en) begin
          res_d = {1'b0, res_q[WIDTH-1:1]};
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_mdu_rs1   = rs1_data;
  assign bus.o_mdu_rs2   = rs2_data;
  assign bus.o_mdu_op    = op_q;
  assign bus.o_mdu_valid = valid_q;
  assign bus.o_done      = done_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  // Result register drains to zero, so this reads 0 outside RESULT.
  assign bus.o_rd_bit    = res_q[0];

endmodule

// File: tb/tb_mdu_serdes.sv
// Self-checking bench for mdu_serdes: transaction-level model plus per-cycle compare.
// Latency: n/a (testbench).
// Backpressure: bench plays both the serial core and a parallel MDU with programmable ready delay.
`timescale 1ns/1ps
module tb_mdu_serdes;
  import mdu_serdes_pkg::*;

  localparam int W = 32;
  localparam int P_IDLE = 0, P_LOAD = 1, P_EXEC = 2, P_RESULT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_serdes_if #(.WIDTH(W)) bus_if ();

  mdu_serdes #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Transaction-level model: phase plus bit counts, operands assembled by bit position.
  int          m_phase;
  int          m_nbits;
  int          m_nout;
  logic [31:0] m_acc1, m_acc2, m_rs1, m_rs2, m_res;
  logic [2:0]  m_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference parallel MDU (RISC-V M semantics).
  function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'b001: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'b010: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_nbits = 0; m_nout = 0;
    m_acc1 = 0; m_acc2 = 0; m_rs1 = 0; m_rs2 = 0; m_res = 0; m_op = 0;
  endtask

  // Applied once per rising edge with the inputs the bench is holding.
  task automatic model_edge();
    case (m_phase)
      P_IDLE: if (bus_if.i_start) begin
        m_op = bus_if.i_op; m_phase = P_LOAD; m_nbits = 0; m_acc1 = 0; m_acc2 = 0;
      end
      P_LOAD: if (bus_if.i_cnt_en) begin
        m_acc1[m_nbits] = bus_if.i_rs1_bit;
        m_acc2[m_nbits] = bus_if.i_rs2_bit;
        m_nbits++;
        if (m_nbits == W) begin m_rs1 = m_acc1; m_rs2 = m_acc2; m_phase = P_EXEC; end
      end
      P_EXEC: if (bus_if.i_mdu_ready) begin
        m_res = bus_if.i_mdu_rd; m_nout = 0; m_phase = P_RESULT;
      end
      default: if (bus_if.i_rd_en) begin
        m_nout++;
        if (m_nout == W) begin m_phase = P_IDLE; m_res = 0; end
      end
    endcase
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",  {31'b0, bus_if.o_busy},      {31'b0, m_phase != P_IDLE});
      check("done",  {31'b0, bus_if.o_done},      {31'b0, m_phase == P_RESULT});
      check("valid", {31'b0, bus_if.o_mdu_valid}, {31'b0, m_phase == P_EXEC});
      check("op",    {29'b0, bus_if.o_mdu_op},    {29'b0, m_op});
      check("rd_bit", {31'b0, bus_if.o_rd_bit},
            {31'b0, (m_phase == P_RESULT) ? m_res[m_nout] : 1'b0});
      if (m_phase != P_LOAD) begin
        check("rs1", bus_if.o_mdu_rs1, m_rs1);
        check("rs2", bus_if.o_mdu_rs2, m_rs2);
      end
    end
  end

  task automatic quiet();
    bus_if.i_start = 0; bus_if.i_op = 0; bus_if.i_cnt_en = 0;
    bus_if.i_rs1_bit = 0; bus_if.i_rs2_bit = 0; bus_if.i_rd_en = 0;
    bus_if.i_mdu_ready = 0; bus_if.i_mdu_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    quiet();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", {31'b0, bus_if.o_mdu_valid}, 32'd0);
    check("rst_done",  {31'b0, bus_if.o_done},      32'd0);
    check("rst_busy",  {31'b0, bus_if.o_busy},      32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full operation. abort: 0 none, 1 reset in EXEC, 2 reset in RESULT.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit gaps, input int delay, input bit junk, input bit start_last,
                        input int abort, output logic [31:0] got);
    int          guard;
    logic [31:0] exp;
    exp = mdu_ref(op, a, b);
    got = 0;
    quiet();
    bus_if.i_start = 1; bus_if.i_op = op;
    bus_if.i_cnt_en = 1; bus_if.i_rs1_bit = ~a[0]; bus_if.i_rs2_bit = ~b[0];
    tick();
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          quiet();
          if (junk) begin
            bus_if.i_start = 1'($urandom); bus_if.i_op = 3'($urandom);
            bus_if.i_mdu_ready = 1'($urandom); bus_if.i_mdu_rd = $urandom;
            bus_if.i_rd_en = 1'($urandom); bus_if.i_rs1_bit = 1'($urandom);
          end
          tick();
        end
      end
      quiet();
      bus_if.i_cnt_en = 1; bus_if.i_rs1_bit = a[i]; bus_if.i_rs2_bit = b[i];
      tick();
    end
    quiet();
    guard = 0;
    while (!bus_if.o_mdu_valid && guard < 4) begin tick(); guard++; end
    check("valid_latency", guard, 0);
    check("par_rs1", bus_if.o_mdu_rs1, a);
    check("par_rs2", bus_if.o_mdu_rs2, b);
    check("par_op", {29'b0, bus_if.o_mdu_op}, {29'b0, op});
    for (int d = 0; d < delay; d++) begin
      quiet();
      if (junk) begin
        bus_if.i_start = 1; bus_if.i_op = 3'($urandom); bus_if.i_cnt_en = 1;
        bus_if.i_rd_en = 1; bus_if.i_mdu_rd = $urandom;
      end
      tick();
    end
    if (abort == 1) begin do_reset(); return; end
    quiet();
    bus_if.i_mdu_ready = 1; bus_if.i_mdu_rd = exp;
    tick();
    quiet();
    check("valid_after_ready", {31'b0, bus_if.o_mdu_valid}, 32'd0);
    check("done_after_ready",  {31'b0, bus_if.o_done},      32'd1);
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          quiet();
          if (junk) begin
            bus_if.i_start = 1'($urandom); bus_if.i_op = 3'($urandom);
            bus_if.i_cnt_en = 1'($urandom); bus_if.i_mdu_ready = 1'($urandom);
            bus_if.i_mdu_rd = $urandom;
          end
          tick();
        end
      end
      if (abort == 2 && i == W / 2) begin do_reset(); return; end
      quiet();
      got[i] = bus_if.o_rd_bit;
      bus_if.i_rd_en = 1;
      if (start_last && i == W - 1) begin bus_if.i_start = 1; bus_if.i_op = 3'($urandom); end
      tick();
    end
    quiet();
    check("shift_out", got, exp);
    check("done_end", {31'b0, bus_if.o_done}, 32'd0);
    check("busy_end", {31'b0, bus_if.o_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a, b;
    logic [2:0]  op;
    quiet();
    model_reset();
    #3;
    check("reset_rs1",   bus_if.o_mdu_rs1, 32'd0);
    check("reset_rs2",   bus_if.o_mdu_rs2, 32'd0);
    check("reset_op",    {29'b0, bus_if.o_mdu_op}, 32'd0);
    check("reset_valid", {31'b0, bus_if.o_mdu_valid}, 32'd0);
    check("reset_done",  {31'b0, bus_if.o_done}, 32'd0);
    check("reset_busy",  {31'b0, bus_if.o_busy}, 32'd0);
    check("reset_rdbit", {31'b0, bus_if.o_rd_bit}, 32'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Pin the reference MDU with hand-computed values.
    check("ref_mulh",  mdu_ref(3'b001, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("ref_div0",  mdu_ref(3'b100, 32'd9, 32'd0), 32'hFFFF_FFFF);
    check("ref_rem",   mdu_ref(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("ref_mulhu", mdu_ref(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    // Idle-state strobes that must be ignored.
    for (int k = 0; k < 4; k++) begin
      quiet();
      bus_if.i_cnt_en = 1; bus_if.i_rd_en = 1; bus_if.i_mdu_ready = 1; bus_if.i_mdu_rd = $urandom;
      tick();
    end
    quiet();

    run_op(OP_MUL, 32'd3, 32'd5, 1'b0, 2, 1'b0, 1'b0, 0, got);
    check("mul_3x5", got, 32'd15);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 34, 1'b1, 1'b0, 0, got);
    check("div_m7_2", got, 32'hFFFF_FFFD);

    a = $urandom; b = $urandom | 32'h1;
    run_op(OP_REMU, a, b, 1'b0, 3, 1'b0, 1'b1, 0, got);
    run_op(OP_MULHU, $urandom, $urandom, 1'b0, 1, 1'b0, 1'b0, 0, got);

    run_op(OP_MUL, 32'h1234, 32'h5678, 1'b1, 5, 1'b1, 1'b0, 1, got);
    run_op(OP_MUL, 32'd7, 32'd6, 1'b0, 2, 1'b0, 1'b0, 0, got);
    check("mul_7x6_a", got, 32'd42);

    run_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, 2, 1'b0, 1'b0, 2, got);
    run_op(OP_MUL, 32'd7, 32'd6, 1'b1, 1, 1'b1, 1'b0, 0, got);
    check("mul_7x6_b", got, 32'd42);

    run_op(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, 0, got);
    check("mul_msb", got, 32'h8000_0000);

    for (int t = 0; t < 10; t++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, 1'($urandom), $urandom_range(0, 12), 1'($urandom), 1'($urandom), 0, got);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
